// File: rtl/fifo_out_wide_pkg.sv
// fifo_out_wide_pkg: shared sizing defaults and half-word select encoding
// for the factorial result FIFO.
package fifo_out_wide_pkg;
    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 3;
    localparam int DEF_DEPTH = 8;
    typedef enum logic {WORD_LO = 1'b0, WORD_HI = 1'b1} half_e;
endpackage

// File: rtl/fifo_out_wide_regfile.sv
// fifo_out_wide_regfile: DEPTH x 2*DW storage, one synchronous write port and
// one combinational read port, no reset.
module fifo_out_wide_regfile #(
    parameter int DW    = 32,
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   wAddr,
    input  logic [2*DW-1:0] wData,
    input  logic [AW-1:0]   rAddr,
    output logic [2*DW-1:0] rData
);
    logic [2*DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) r_mem[wAddr] <= wData;
    end

    assign rData = r_mem[rAddr];
endmodule

// File: rtl/fifo_out_wide.sv
// fifo_out_wide: result FIFO taking 2*DW-bit writes and returning DW-bit reads,
// low word first, with registered read data and registered ack/err pulses.
module fifo_out_wide
    import fifo_out_wide_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [2*DW-1:0] din,
    input  logic            rd_en,
    output logic [DW-1:0]   dout,
    output logic            full,
    output logic            empty,
    output logic            wr_ack,
    output logic            wr_err,
    output logic            rd_ack,
    output logic            rd_err,
    output logic [AW+1:0]   data_count
);
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_cnt;
    half_e           r_half;
    logic [DW-1:0]   r_dout;
    logic            r_wr_ack, r_wr_err, r_rd_ack, r_rd_err;
    logic            w_wr, w_rd, w_free;
    logic [2*DW-1:0] w_rdata;

    fifo_out_wide_regfile #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_regfile (
        .clk   (clk),
        .we    (w_wr),
        .wAddr (r_wptr),
        .wData (din),
        .rAddr (r_rptr),
        .rData (w_rdata)
    );

    // A word count that is odd means the low half of the head entry is already gone.
    assign data_count = {1'b0, r_cnt, 1'b0} - {{(AW+1){1'b0}}, r_half};
    assign full       = r_cnt == (AW+1)'(DEPTH);
    assign empty      = data_count == '0;
    assign w_wr       = wr_en & ~full;
    assign w_rd       = rd_en & ~empty;
    assign w_free     = w_rd & (r_half == WORD_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_half   <= WORD_LO;
            r_dout   <= '0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_free) r_rptr <= r_rptr + 1'b1;
            if (w_rd) r_half <= (r_half == WORD_LO) ? WORD_HI : WORD_LO;
            r_cnt    <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_free);
            r_dout   <= w_rd ? ((r_half == WORD_HI) ? w_rdata[2*DW-1:DW] : w_rdata[DW-1:0]) : '0;
            r_wr_ack <= w_wr;
            r_wr_err <= wr_en & full;
            r_rd_ack <= w_rd;
            r_rd_err <= rd_en & empty;
        end
    end

    assign dout   = r_dout;
    assign wr_ack = r_wr_ack;
    assign wr_err = r_wr_err;
    assign rd_ack = r_rd_ack;
    assign rd_err = r_rd_err;
endmodule
